// File: rtl/ysyx_23060124_lsu_sram_if.sv
// Request/response bus between the LSU and its data memory.
// Signal names are taken from the memory side, so i_* are driven by the LSU and o_* by the memory.
interface ysyx_23060124_lsu_sram_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_wen;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_wmask;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    modport master (
        output i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wmask, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_wen, i_req_addr, i_req_wdata, i_req_wmask, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );
endinterface

// File: rtl/ysyx_23060124_lsu_sram.sv
// Single-outstanding data memory for the LSU: byte-writable word array answering each
// request after a fixed latency, optionally stretched by a small LFSR-driven jitter.
module ysyx_23060124_lsu_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LAT         = 2,
    parameter int          RAND_LAT    = 0
) (
    input  logic                            clk,
    input  logic                            i_rst_n,
    ysyx_23060124_lsu_sram_if.slave         bus
);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam int          CNT_W    = $clog2(LAT + 4);
    localparam logic [32:0] BASE_33  = {1'b0, ADDR_BASE};
    localparam logic [32:0] LIMIT_33 = BASE_33 + (33'(DEPTH_WORDS) << 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_lfsr;
    logic              r_wen;
    logic [IDX_W-1:0]  r_idx;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wmask;
    logic              r_err;
    logic              r_rsp_err;
    logic              r_rd_sel;
    logic [31:0]       r_mem_q;

    state_t            w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  w_delay;
    logic              w_accept;
    logic              w_enter_resp;
    logic              w_rsp_done;
    logic [32:0]       w_addr_33;
    logic [31:0]       w_addr_off;
    logic              w_in_err;
    logic [IDX_W-1:0]  w_in_idx;
    logic [3:0]        w_lfsr_next;
    logic              w_acc_wen;
    logic              w_acc_err;
    logic [IDX_W-1:0]  w_acc_idx;
    logic [31:0]       w_acc_wdata;
    logic [3:0]        w_acc_wmask;
    logic              w_mem_re;
    logic [3:0]        w_lane_we;

    assign w_accept    = bus.i_req_valid && (r_state == S_IDLE);
    assign w_lfsr_next = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};

    // Range test in 33 bits so addresses near 32'hFFFF_FFFC cannot wrap into the window.
    assign w_addr_33  = {1'b0, bus.i_req_addr};
    assign w_in_err   = !((w_addr_33 >= BASE_33) && (w_addr_33 < LIMIT_33));
    assign w_addr_off = bus.i_req_addr - ADDR_BASE;
    assign w_in_idx   = IDX_W'(w_addr_off >> 2);

    always_comb begin
        w_delay = CNT_W'(LAT);
        if (RAND_LAT != 0) begin
            w_delay = CNT_W'(LAT) + CNT_W'(r_lfsr[1:0]);
        end
    end

    // With a one-cycle latency the memory is touched on the accept edge itself,
    // before the request fields have been latched, so take them straight from the bus.
    assign w_acc_wen   = (r_state == S_IDLE) ? bus.i_req_wen   : r_wen;
    assign w_acc_err   = (r_state == S_IDLE) ? w_in_err        : r_err;
    assign w_acc_idx   = (r_state == S_IDLE) ? w_in_idx        : r_idx;
    assign w_acc_wdata = (r_state == S_IDLE) ? bus.i_req_wdata : r_wdata;
    assign w_acc_wmask = (r_state == S_IDLE) ? bus.i_req_wmask : r_wmask;

    assign w_mem_re = w_enter_resp && !w_acc_wen && !w_acc_err;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane_we
            assign w_lane_we[gi] = w_enter_resp && w_acc_wen && !w_acc_err && w_acc_wmask[gi];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_enter_resp = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_delay == CNT_W'(1)) begin
                        w_state_next = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = S_BUSY;
                        w_cnt_next   = w_delay - CNT_W'(2);
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.i_rsp_ready) begin
                    w_state_next = S_IDLE;
                    w_rsp_done   = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_lfsr    <= 4'b1001;
            r_wen     <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_err     <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rd_sel  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_lfsr  <= w_lfsr_next;
                r_wen   <= bus.i_req_wen;
                r_idx   <= w_in_idx;
                r_wdata <= bus.i_req_wdata;
                r_wmask <= bus.i_req_wmask;
                r_err   <= w_in_err;
            end
            if (w_enter_resp) begin
                r_rsp_err <= w_acc_err;
                r_rd_sel  <= w_mem_re;
            end else if (w_rsp_done) begin
                r_rsp_err <= 1'b0;
                r_rd_sel  <= 1'b0;
            end
        end
    end

    // Memory and its read register carry no reset; the read value is gated by r_rd_sel instead.
    always_ff @(posedge clk) begin
        if (w_mem_re) begin
            r_mem_q <= mem[w_acc_idx];
        end
        for (int b = 0; b < 4; b++) begin
            if (w_lane_we[b]) begin
                mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
            end
        end
    end

    assign bus.o_req_ready = (r_state == S_IDLE);
    assign bus.o_rsp_valid = (r_state == S_RESP);
    assign bus.o_rsp_rdata = r_rd_sel ? r_mem_q : 32'h0;
    assign bus.o_rsp_err   = r_rsp_err;
endmodule
